// File: rtl/dds_tdm_scheduler.sv
// dds_tdm_scheduler: time-shares one dds pipeline among NUM_CH NCO channels.
// Round-robin issue of per-channel phase accumulators to the dds phase input,
// with a channel-tag delay line that re-attaches the channel index to the
// returning sin/cos sample.
module dds_tdm_scheduler #(
  parameter  int NUM_CH      = 4,
  parameter  int PHASE_DW    = 16,
  parameter  int OUT_DW      = 16,
  parameter  int DDS_LATENCY = 4,
  localparam int CH_W        = $clog2(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  sample_en,
  input  logic                  cfg_wr,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [PHASE_DW-1:0]   cfg_freq,
  input  logic                  cfg_en,
  input  logic                  cfg_clr,
  output logic [PHASE_DW-1:0]   m_phase_tdata,
  output logic                  m_phase_tvalid,
  input  logic [2*OUT_DW-1:0]   s_dds_tdata,
  input  logic                  s_dds_tvalid,
  output logic [2*OUT_DW-1:0]   m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic [CH_W-1:0]       m_axis_tuser,
  output logic                  busy,
  output logic                  done,
  output logic                  tag_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_t;

  localparam int FCNT_W = $clog2(DDS_LATENCY + 2);

  state_t                state, state_nxt;
  logic [FCNT_W-1:0]     flush_cnt;
  logic                  flush_last;

  logic [PHASE_DW-1:0]   acc  [NUM_CH];
  logic [PHASE_DW-1:0]   freq [NUM_CH];
  logic [NUM_CH-1:0]     en;
  logic [CH_W-1:0]       rr_ptr;

  logic [CH_W-1:0]       sel_ch;
  logic                  any_en;
  logic                  issue;
  logic                  cfg_ok;

  logic                  tag_v  [DDS_LATENCY];
  logic [CH_W-1:0]       tag_ch [DDS_LATENCY];

  assign flush_last = (state == S_FLUSH) && (flush_cnt == FCNT_W'(DDS_LATENCY));
  assign busy       = (state != S_IDLE);
  assign issue      = (state == S_RUN) && !stop && sample_en && any_en;
  assign cfg_ok     = (32'(cfg_ch) < 32'(NUM_CH));

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: stop has priority over start while running.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start)      state_nxt = S_RUN;
      S_RUN:   if (stop)       state_nxt = S_FLUSH;
      S_FLUSH: if (flush_last) state_nxt = S_IDLE;
      default:                 state_nxt = S_IDLE;
    endcase
  end

  // Flush length counter and the done pulse on FLUSH->IDLE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flush_cnt <= '0;
      done      <= 1'b0;
    end else begin
      flush_cnt <= (state == S_FLUSH) ? flush_cnt + 1'b1 : '0;
      done      <= flush_last;
    end
  end

  // Round-robin pick: first enabled channel after rr_ptr, wrapping.
  always_comb begin
    any_en = 1'b0;
    sel_ch = '0;
    for (int unsigned k = 1; k <= 32'(NUM_CH); k++) begin
      logic [CH_W-1:0] idx;
      idx = CH_W'((32'(rr_ptr) + k) % 32'(NUM_CH));
      if (!any_en && en[idx]) begin
        any_en = 1'b1;
        sel_ch = idx;
      end
    end
  end

  // Per-channel accumulators and config; the config write is placed after the
  // issue update so a same-cycle cfg_clr on the issuing channel overrides it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 32'(NUM_CH); i++) begin
        acc[i]  <= '0;
        freq[i] <= '0;
      end
      en <= '0;
    end else begin
      if (issue) acc[sel_ch] <= acc[sel_ch] + freq[sel_ch];
      if (cfg_wr && cfg_ok) begin
        freq[cfg_ch] <= cfg_freq;
        en[cfg_ch]   <= cfg_en;
        if (cfg_clr) acc[cfg_ch] <= '0;
      end
    end
  end

  // Issue register towards the dds phase input.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m_phase_tdata  <= '0;
      m_phase_tvalid <= 1'b0;
      rr_ptr         <= CH_W'(NUM_CH - 1);
    end else begin
      m_phase_tvalid <= issue;
      if (issue) begin
        m_phase_tdata <= acc[sel_ch];
        rr_ptr        <= sel_ch;
      end
    end
  end

  // Tag delay line; the issue register acts as stage 0 (rr_ptr holds the
  // issued channel), so DDS_LATENCY extra stages line up with s_dds_tvalid.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 32'(DDS_LATENCY); i++) begin
        tag_v[i]  <= 1'b0;
        tag_ch[i] <= '0;
      end
    end else begin
      tag_v[0]  <= m_phase_tvalid;
      tag_ch[0] <= rr_ptr;
      for (int unsigned i = 1; i < 32'(DDS_LATENCY); i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_ch[i] <= tag_ch[i-1];
      end
    end
  end

  // Tagged output register and sticky tag/valid consistency flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= '0;
      tag_err       <= 1'b0;
    end else begin
      m_axis_tdata  <= s_dds_tdata;
      m_axis_tvalid <= s_dds_tvalid;
      m_axis_tuser  <= tag_ch[DDS_LATENCY-1];
      tag_err       <= tag_err | (tag_v[DDS_LATENCY-1] != s_dds_tvalid);
    end
  end

endmodule
